hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core: owns all stall/flush/bubble decisions for PC, IF/ID, ID/EX, EX/MEM.
//  Resolves jump flush, load-use hazard, multi-cycle EX ops (mul/div) and data-bus wait.
//  Drives start/handshake of the multi-cycle unit. Keeps saturating stall/flush perf counters.
// PARAMETERS
//  REG_AW      5      register address width
//  CNT_W       32     perf counter width
//  MC_TIMEOUT  64     max cycles in MC_WAIT before abort (>=2)
// PORTS
//  clk             in   1       core clock
//  rest            in   1       sync reset, active-high (`RESET == 1'b1)
//  id_rs1_addr_i   in   REG_AW  ID-stage source 1
//  id_rs2_addr_i   in   REG_AW  ID-stage source 2
//  id_rs1_rd_i     in   1       ID reads rs1
//  id_rs2_rd_i     in   1       ID reads rs2
//  ex_rd_addr_i    in   REG_AW  EX-stage destination
//  ex_load_i       in   1       EX instruction is a load
//  ex_jump_en_i    in   1       EX resolved taken jump/branch
//  ex_mc_req_i     in   1       EX instruction is multi-cycle
//  mc_done_i       in   1       multi-cycle unit result valid (1-cycle pulse)
//  mem_busy_i      in   1       data bus not ready
//  pc_jump_en_o    out  1       load PC with jump target
//  pc_stall_o      out  1       hold PC
//  ifid_stall_o    out  1       hold IF/ID
//  ifid_flush_o    out  1       clear IF/ID to NOP
//  idex_stall_o    out  1       hold ID/EX
//  idex_flush_o    out  1       clear ID/EX to NOP (bubble)
//  exmem_stall_o   out  1       hold EX/MEM
//  mc_start_o      out  1       start pulse to multi-cycle unit
//  mc_err_o        out  1       sticky: MC timeout occurred
//  stall_cnt_o     out  CNT_W   cycles with pc_stall_o=1
//  flush_cnt_o     out  CNT_W   cycles with pc_jump_en_o=1
// BEHAVIOUR
//  Reset: state=RUN, all outputs 0, counters 0, mc_err_o 0. Reset mid-MC_WAIT aborts to RUN, no start reissued.
//  FSM states: RUN, MC_WAIT.
//   RUN->MC_WAIT: ex_mc_req_i=1 & !mem_busy_i. mc_start_o=1 that cycle only (Mealy), timeout cnt<=0.
//   MC_WAIT->RUN: mc_done_i=1, or timeout cnt reaches MC_TIMEOUT-1 (then mc_err_o<=1, sticky until reset).
//   mc_done_i ignored in RUN; ex_jump_en_i ignored in MC_WAIT (EX holds the MC op).
//  Stall/flush outputs combinational from state+inputs, priority high->low:
//   1 mem_busy_i: pc,ifid,idex,exmem stall=1; no flush; no mc_start; FSM holds.
//   2 MC_WAIT & !mc_done_i, or RUN & ex_mc_req_i: pc,ifid,idex stall=1, exmem_stall_o=0, idex_flush_o=0.
//     Done cycle: all stall=0, op advances at that edge.
//   3 ex_jump_en_i (RUN): pc_jump_en_o=1, ifid_flush_o=1, idex_flush_o=1, no stall.
//   4 load-use: ex_load_i & ex_rd_addr_i!=0 & ((id_rs1_rd_i & rs1==rd)|(id_rs2_rd_i & rs2==rd)):
//     pc,ifid stall=1, idex_flush_o=1 (one bubble); clears next cycle as load leaves EX.
//   5 else all 0.
//  Jump and load-use same cycle: jump wins, no stall.
//  Counters: +1 per qualifying cycle, saturate at all-ones, no wrap; registered (visible next cycle).
// STRUCTURE
//  global.v: add `HZ_RUN/`HZ_MC_WAIT state codes; reuse `ENABLE/`DISABLE/`RESET.
//  Sub-module hazard_sat_cnt (CNT_W, en -> saturating count), instanced for stall and flush counters.
//  Timeout counter $clog2(MC_TIMEOUT) bits, inline.
// TESTING
//  Reset 2 cycles with all inputs 1 -> all outputs 0, counters 0 during and after.
//  ex_load_i=1, ex_rd=5, id_rs1_rd=1, rs1=5 for 1 cycle -> pc/ifid stall=1, idex_flush=1 one cycle; stall_cnt=1. Same with rd=0 -> no stall.
//  ex_mc_req_i=1, mc_done_i 4 cycles after start -> mc_start_o one pulse, stall=1 for 4 cycles, 0 on done cycle, stall_cnt=4.
//  ex_mc_req_i held, no done, MC_TIMEOUT=8 -> back to RUN after 8 MC_WAIT cycles, mc_err_o=1 and stays 1.
//  ex_jump_en_i=1 with load-use match -> pc_jump_en/ifid_flush/idex_flush=1, stalls=0, flush_cnt=1.
//  mem_busy_i=1 during MC_WAIT with mc_done_i -> all four stalls=1, FSM stays MC_WAIT; CNT_W=4, 20 stall cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state codes, control bundle and constants for the hazard controller
package hazard_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic RESET   = 1'b1;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MC_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_jump_en;
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic mc_start;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// rtl/hazard_sat_cnt.sv - saturating event counter, holds at all-ones instead of wrapping
module hazard_sat_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rest == RESET) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer: jump flush, load-use bubble, multi-cycle EX and bus wait
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs1_rd_i,
  input  logic              id_rs2_rd_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic              ex_load_i,
  input  logic              ex_jump_en_i,
  input  logic              ex_mc_req_i,
  input  logic              mc_done_i,
  input  logic              mem_busy_i,
  output logic              pc_jump_en_o,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_stall_o,
  output logic              idex_flush_o,
  output logic              exmem_stall_o,
  output logic              mc_start_o,
  output logic              mc_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int              TO_W    = $clog2(MC_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  hz_state_e       r_state;
  hz_state_e       w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_mc_err;
  hz_ctrl_t        w_ctrl;
  logic            w_to_clr;
  logic            w_to_inc;
  logic            w_err_set;
  logic            w_load_use;
  logic            w_mc_hold;

  assign w_load_use = ex_load_i && (ex_rd_addr_i != '0) &&
                      ((id_rs1_rd_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_rd_i && (id_rs2_addr_i == ex_rd_addr_i)));

  assign w_mc_hold = ((r_state == HZ_MC_WAIT) && !mc_done_i) ||
                     ((r_state == HZ_RUN) && ex_mc_req_i);

  // Outputs are forced low while reset is asserted so the pipeline sees no spurious control.
  always_comb begin
    w_ctrl    = '0;
    w_next    = r_state;
    w_to_clr  = DISABLE;
    w_to_inc  = DISABLE;
    w_err_set = DISABLE;
    if (rest == RESET) begin
      w_next = HZ_RUN;
    end else if (mem_busy_i) begin
      w_ctrl.pc_stall    = ENABLE;
      w_ctrl.ifid_stall  = ENABLE;
      w_ctrl.idex_stall  = ENABLE;
      w_ctrl.exmem_stall = ENABLE;
    end else if (w_mc_hold) begin
      w_ctrl.pc_stall   = ENABLE;
      w_ctrl.ifid_stall = ENABLE;
      w_ctrl.idex_stall = ENABLE;
      if (r_state == HZ_RUN) begin
        w_ctrl.mc_start = ENABLE;
        w_next          = HZ_MC_WAIT;
        w_to_clr        = ENABLE;
      end else if (r_to_cnt == TO_LAST) begin
        w_next    = HZ_RUN;
        w_err_set = ENABLE;
      end else begin
        w_to_inc = ENABLE;
      end
    end else if (r_state == HZ_MC_WAIT) begin
      // Done cycle: release every stall, the MC op leaves EX at this edge.
      w_next = HZ_RUN;
    end else if (ex_jump_en_i) begin
      w_ctrl.pc_jump_en = ENABLE;
      w_ctrl.ifid_flush = ENABLE;
      w_ctrl.idex_flush = ENABLE;
    end else if (w_load_use) begin
      w_ctrl.pc_stall   = ENABLE;
      w_ctrl.ifid_stall = ENABLE;
      w_ctrl.idex_flush = ENABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rest == RESET) begin
      r_state  <= HZ_RUN;
      r_to_cnt <= '0;
      r_mc_err <= DISABLE;
    end else begin
      r_state <= w_next;
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
      if (w_err_set) begin
        r_mc_err <= ENABLE;
      end
    end
  end

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rest  (rest),
    .en_i  (w_ctrl.pc_stall),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rest  (rest),
    .en_i  (w_ctrl.pc_jump_en),
    .cnt_o (flush_cnt_o)
  );

  assign pc_jump_en_o  = w_ctrl.pc_jump_en;
  assign pc_stall_o    = w_ctrl.pc_stall;
  assign ifid_stall_o  = w_ctrl.ifid_stall;
  assign ifid_flush_o  = w_ctrl.ifid_flush;
  assign idex_stall_o  = w_ctrl.idex_stall;
  assign idex_flush_o  = w_ctrl.idex_flush;
  assign exmem_stall_o = w_ctrl.exmem_stall;
  assign mc_start_o    = w_ctrl.mc_start;
  assign mc_err_o      = r_mc_err;

endmodule
